// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Brings CHANNELS asynchronous raw inputs into the ap_clk domain. Each
//   input passes through a synchronizer chain and then a debounce counter.
//   Accepted level changes produce one-cycle rise/fall pulses. They are also
//   collected into a pending mask that a consumer drains through a
//   valid/ready handshake. If a channel changes again before its earlier
//   change has been consumed, a sticky overflow flag is set.
//
// Parameters:
//   CHANNELS        number of independent input channels (1..32)
//   SYNC_STAGES     flip-flop depth of each synchronizer chain (2..4)
//   DEBOUNCE_CYCLES cycles a synchronized value must persist (1..65535)
//
// Ports:
//   ap_clk        in   sole clock
//   ap_rst_n      in   asynchronous active-low reset
//   din           in   [CHANNELS] raw asynchronous inputs
//   stable        out  [CHANNELS] debounced, synchronized level
//   rise          out  [CHANNELS] one-cycle pulse on stable 0->1
//   fall          out  [CHANNELS] one-cycle pulse on stable 1->0
//   event_valid   out  at least one channel has an unconsumed edge
//   event_ready   in   consumer accepts the pending event
//   event_mask    out  [CHANNELS] channels with unconsumed edges
//   event_state   out  [CHANNELS] copy of stable, aligned with event_mask
//   overflow      out  sticky: an edge hit an already-pending channel
//   clr_overflow  in   synchronous clear of overflow
// ---------------------------------------------------------------------------
module input_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] stable,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [CHANNELS-1:0] event_mask,
    output logic [CHANNELS-1:0] event_state,
    output logic                overflow,
    input  logic                clr_overflow
);

    // A single-cycle debounce still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_out;

    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    logic [CHANNELS-1:0] stable_q;
    logic [CHANNELS-1:0] stable_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;
    logic [CHANNELS-1:0] edge_d;
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] pend_d;

    logic                valid_q;
    logic                consume;
    logic                ovf_q;
    logic                ovf_set;
    logic                ovf_d;

    // Plain flip-flop chain per bit; nothing may sit between the stages or
    // the metastability settling time is eaten by logic delay.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= din;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Debounce: the counter tracks how long the synchronized value has
    // disagreed with the accepted level. It is accepted on the cycle the
    // counter has already reached its maximum, so the counter never wraps.
    always_comb begin
        stable_d = stable_q;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = '0;
            if (sync_out[c] != stable_q[c]) begin
                if (cnt_q[c] == CNT_MAX) begin
                    stable_d[c] = sync_out[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // Edges, pending mask and overflow are all derived from this cycle's
    // update. That lets rise/fall, stable and the event interface move on
    // the same clock edge.
    always_comb begin
        rise_d  = stable_d & ~stable_q;
        fall_d  = ~stable_d & stable_q;
        edge_d  = rise_d | fall_d;
        consume = valid_q & event_ready;
        pend_d  = (pend_q & ~{CHANNELS{consume}}) | edge_d;
        ovf_set = (|(edge_d & pend_q)) & ~consume;
        ovf_d   = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // Per-channel debounce state and registered edge pulses.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Event handshake state. event_valid is registered from the next pend
    // value so it always agrees with event_mask.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= |pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign stable      = stable_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign event_valid = valid_q;
    assign event_mask  = pend_q;
    assign event_state = stable_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner with CHANNELS=4, SYNC_STAGES=3,
// DEBOUNCE_CYCLES=4. A level change held on din becomes visible on stable
// 7 clock edges after the first edge that samples it.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       event_valid;
    logic       event_ready;
    logic [3:0] event_mask;
    logic [3:0] event_state;
    logic       overflow;
    logic       clr_overflow;

    int checks;
    int passed;

    input_conditioner #(
        .CHANNELS        (4),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .din          (din),
        .stable       (stable),
        .rise         (rise),
        .fall         (fall),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_mask   (event_mask),
        .event_state  (event_state),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with all inputs low and let the pipeline settle.
    task automatic do_reset();
        rst_n        = 1'b0;
        din          = 4'h0;
        event_ready  = 1'b0;
        clr_overflow = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        din          = 4'hF;
        event_ready  = 1'b0;
        clr_overflow = 1'b0;
        #1;
        checks++; if (stable !== 4'h0) $display("[TB] FAIL reset_stable: got %h want %h", stable, 4'h0); else passed++;
        checks++; if (rise !== 4'h0) $display("[TB] FAIL reset_rise: got %h want %h", rise, 4'h0); else passed++;
        checks++; if (fall !== 4'h0) $display("[TB] FAIL reset_fall: got %h want %h", fall, 4'h0); else passed++;
        checks++; if (event_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", event_valid); else passed++;
        checks++; if (event_mask !== 4'h0) $display("[TB] FAIL reset_mask: got %h want %h", event_mask, 4'h0); else passed++;
        checks++; if (event_state !== 4'h0) $display("[TB] FAIL reset_state: got %h want %h", event_state, 4'h0); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b want 0", overflow); else passed++;
        tick(3);
        checks++; if (stable !== 4'h0) $display("[TB] FAIL reset_held_stable: got %h want %h", stable, 4'h0); else passed++;
        rst_n = 1'b1;
        tick(6);
        checks++; if (stable !== 4'h0) $display("[TB] FAIL reset_edge6_stable: got %h want %h", stable, 4'h0); else passed++;
        tick(1);
        checks++; if (stable !== 4'hF) $display("[TB] FAIL reset_edge7_stable: got %h want %h", stable, 4'hF); else passed++;
        checks++; if (rise !== 4'hF) $display("[TB] FAIL reset_edge7_rise: got %h want %h", rise, 4'hF); else passed++;
        checks++; if (event_valid !== 1'b1) $display("[TB] FAIL reset_edge7_valid: got %b want 1", event_valid); else passed++;
        checks++; if (event_mask !== 4'hF) $display("[TB] FAIL reset_edge7_mask: got %h want %h", event_mask, 4'hF); else passed++;
        event_ready = 1'b1;
        tick(1);
        event_ready = 1'b0;
        checks++; if (event_valid !== 1'b0) $display("[TB] FAIL reset_consume_valid: got %b want 0", event_valid); else passed++;
        checks++; if (event_mask !== 4'h0) $display("[TB] FAIL reset_consume_mask: got %h want %h", event_mask, 4'h0); else passed++;
        checks++; if (rise !== 4'h0) $display("[TB] FAIL reset_rise_pulse: got %h want %h", rise, 4'h0); else passed++;
    endtask

    task automatic test_clean_edge();
        do_reset();
        din = 4'b0001;
        tick(6);
        checks++; if (stable !== 4'h0) $display("[TB] FAIL clean_edge6_stable: got %h want %h", stable, 4'h0); else passed++;
        checks++; if (rise !== 4'h0) $display("[TB] FAIL clean_edge6_rise: got %h want %h", rise, 4'h0); else passed++;
        tick(1);
        checks++; if (stable !== 4'b0001) $display("[TB] FAIL clean_edge7_stable: got %h want %h", stable, 4'b0001); else passed++;
        checks++; if (rise !== 4'b0001) $display("[TB] FAIL clean_edge7_rise: got %h want %h", rise, 4'b0001); else passed++;
        checks++; if (event_valid !== 1'b1) $display("[TB] FAIL clean_edge7_valid: got %b want 1", event_valid); else passed++;
        checks++; if (event_mask !== 4'b0001) $display("[TB] FAIL clean_edge7_mask: got %h want %h", event_mask, 4'b0001); else passed++;
        checks++; if (event_state !== 4'b0001) $display("[TB] FAIL clean_edge7_state: got %h want %h", event_state, 4'b0001); else passed++;
        tick(1);
        checks++; if (rise !== 4'h0) $display("[TB] FAIL clean_rise_width: got %h want %h", rise, 4'h0); else passed++;
        checks++; if (event_mask !== 4'b0001) $display("[TB] FAIL clean_mask_held: got %h want %h", event_mask, 4'b0001); else passed++;
        din = 4'b0000;
        tick(7);
        checks++; if (fall !== 4'b0001) $display("[TB] FAIL clean_fall: got %h want %h", fall, 4'b0001); else passed++;
        checks++; if (stable !== 4'h0) $display("[TB] FAIL clean_fall_stable: got %h want %h", stable, 4'h0); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL clean_fall_overflow: got %b want 1", overflow); else passed++;
    endtask

    task automatic test_glitch();
        do_reset();
        din = 4'b0010;
        tick(3);
        din = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++; if (stable !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || event_valid !== 1'b0)
                $display("[TB] FAIL glitch_cycle%0d: got stable=%h rise=%h fall=%h valid=%b want all 0",
                         i, stable, rise, fall, event_valid);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        din = 4'b0001;
        tick(7);
        checks++; if (event_mask !== 4'b0001) $display("[TB] FAIL bp_first_mask: got %h want %h", event_mask, 4'b0001); else passed++;
        din = 4'b0101;
        tick(7);
        checks++; if (event_mask !== 4'b0101) $display("[TB] FAIL bp_second_mask: got %h want %h", event_mask, 4'b0101); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL bp_no_overflow: got %b want 0", overflow); else passed++;
        din = 4'b0100;
        tick(6);
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL bp_overflow_early: got %b want 0", overflow); else passed++;
        tick(1);
        checks++; if (fall !== 4'b0001) $display("[TB] FAIL bp_fall: got %h want %h", fall, 4'b0001); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow_set: got %b want 1", overflow); else passed++;
        checks++; if (event_mask !== 4'b0101) $display("[TB] FAIL bp_mask_kept: got %h want %h", event_mask, 4'b0101); else passed++;
        tick(2);
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow_sticky: got %b want 1", overflow); else passed++;
        clr_overflow = 1'b1;
        tick(1);
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL bp_overflow_clr: got %b want 0", overflow); else passed++;
        din = 4'b0101;
        tick(7);
        checks++; if (rise !== 4'b0001) $display("[TB] FAIL bp_rerise: got %h want %h", rise, 4'b0001); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL bp_set_beats_clr: got %b want 1", overflow); else passed++;
        tick(1);
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL bp_clr_after_set: got %b want 0", overflow); else passed++;
        clr_overflow = 1'b0;
        event_ready  = 1'b1;
        tick(1);
        event_ready  = 1'b0;
        checks++; if (event_mask !== 4'h0) $display("[TB] FAIL bp_drain_mask: got %h want %h", event_mask, 4'h0); else passed++;
        checks++; if (event_valid !== 1'b0) $display("[TB] FAIL bp_drain_valid: got %b want 0", event_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        din = 4'b0001;
        tick(7);
        checks++; if (event_mask !== 4'b0001) $display("[TB] FAIL b2b_first_mask: got %h want %h", event_mask, 4'b0001); else passed++;
        din = 4'b1001;
        tick(6);
        checks++; if (event_mask !== 4'b0001) $display("[TB] FAIL b2b_pre_mask: got %h want %h", event_mask, 4'b0001); else passed++;
        event_ready = 1'b1;
        tick(1);
        event_ready = 1'b0;
        checks++; if (rise !== 4'b1000) $display("[TB] FAIL b2b_rise: got %h want %h", rise, 4'b1000); else passed++;
        checks++; if (event_mask !== 4'b1000) $display("[TB] FAIL b2b_mask: got %h want %h", event_mask, 4'b1000); else passed++;
        checks++; if (event_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b want 1", event_valid); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL b2b_overflow: got %b want 0", overflow); else passed++;
        tick(1);
        checks++; if (event_mask !== 4'b1000) $display("[TB] FAIL b2b_mask_held: got %h want %h", event_mask, 4'b1000); else passed++;
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        din = 4'b0100;
        tick(5);
        rst_n = 1'b0;
        #1;
        checks++; if (stable !== 4'h0 || event_valid !== 1'b0 || event_mask !== 4'h0)
            $display("[TB] FAIL mid_reset_outputs: got stable=%h valid=%b mask=%h want 0", stable, event_valid, event_mask);
        else passed++;
        din = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++; if (rise !== 4'h0 || stable !== 4'h0 || event_valid !== 1'b0)
                $display("[TB] FAIL mid_reset_cycle%0d: got rise=%h stable=%h valid=%b want 0",
                         i, rise, stable, event_valid);
            else passed++;
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        din          = 4'h0;
        event_ready  = 1'b0;
        clr_overflow = 1'b0;
        checks       = 0;
        passed       = 0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
